// File: rtl/hash_req_arbiter_if.sv
// Request/response bundle between the lookup request sources and the
// shared hash arbiter. Keys come in on the request side. Hashed results
// go out on the response side, tagged with the requester that issued them.
interface hash_req_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);

  // Request side: one key slot per requester, one-hot accept strobe back.
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*48-1:0] req_key;
  logic [NUM_REQ-1:0]    req_ready;

  // Response side: head of the response FIFO, popped by resp_ready.
  logic                  resp_valid;
  logic [31:0]           resp_hash;
  logic [ID_W-1:0]       resp_id;
  logic                  resp_ready;

  // Arbiter view.
  modport slave (
    input  req_valid,
    input  req_key,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_hash,
    output resp_id
  );

  // Requester / response consumer view.
  modport master (
    output req_valid,
    output req_key,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_hash,
    input  resp_id
  );

endinterface

// File: rtl/hash_req_arbiter.sv
// Shares one fully pipelined 48-bit -> 32-bit one-at-a-time hash core
// among NUM_REQ requesters. A round-robin arbiter issues at most one key
// per cycle. A valid/ID tag pipe follows each key through the core. The
// results land in a response FIFO. A credit counter covers keys in flight
// plus FIFO entries, so the non-stallable core can never overrun the FIFO.
module hash_req_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int ID_W         = 2,
  parameter int HASH_LATENCY = 7,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                enable,
  hash_req_arbiter_if.slave   bus,
  output logic [47:0]         hash_in_data,
  input  logic [31:0]         hash_out_data,
  output logic                busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
  localparam logic [ID_W-1:0]  LAST_REQ  = ID_W'(NUM_REQ - 1);

  // ---------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  scan;
  logic [ID_W-1:0]  winner;
  logic             found;
  logic             can_issue;
  logic             accept;
  logic             pop;
  logic [CNT_W-1:0] reserved;
  logic [47:0]      win_key;

  // Round-robin search: start one past the last winner and wrap modulo NUM_REQ.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves it unassigned and no latch is inferred.
    winner = rr_ptr;
    found  = 1'b0;
    scan   = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = (scan == LAST_REQ) ? '0 : scan + ID_W'(1);
      if (!found && bus.req_valid[scan]) begin
        found  = 1'b1;
        winner = scan;
      end
    end
  end

  // A key may only be issued while a FIFO slot is still unclaimed. The
  // grant is also held off while reset is asserted, so req_ready reads 0
  // during reset whatever the requesters are driving.
  assign can_issue     = enable && (reserved < DEPTH_C);
  assign accept        = found && can_issue && resetn;
  assign bus.req_ready = accept ? (NUM_REQ'(1) << winner) : '0;
  assign win_key       = bus.req_key[winner*48 +: 48];

  // The pointer follows the last winner. The key register feeds the core and holds when idle.
  always_ff @(posedge clk or negedge resetn) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!resetn) begin
      rr_ptr       <= LAST_REQ;
      hash_in_data <= '0;
    end else if (accept) begin
      rr_ptr       <= winner;
      hash_in_data <= win_key;
    end
  end

  // ---------------------------------------------------------------------
  // Tag pipe
  // ---------------------------------------------------------------------
  // Stage 0 is loaded together with hash_in_data. HASH_LATENCY more stages
  // follow, matching the core, so the last stage is valid in the same cycle
  // that hash_out_data carries that key's hash.
  logic [HASH_LATENCY:0]           tag_valid;
  logic [HASH_LATENCY:0][ID_W-1:0] tag_id;
  logic                            wr_en;
  logic [ID_W-1:0]                 wr_id;

  // Shift the valid/ID tags along with the key as it moves through the core.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tag_valid <= '0;
      tag_id    <= '0;
    end else begin
      tag_valid <= {tag_valid[HASH_LATENCY-1:0], accept};
      tag_id    <= {tag_id[HASH_LATENCY-1:0], winner};
    end
  end

  assign wr_en = tag_valid[HASH_LATENCY];
  assign wr_id = tag_id[HASH_LATENCY];

  // ---------------------------------------------------------------------
  // Response FIFO
  // ---------------------------------------------------------------------
  logic [31:0]      mem_hash [FIFO_DEPTH];
  logic [ID_W-1:0]  mem_id   [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_next;
  logic [CNT_W-1:0] count;
  logic [31:0]      head_hash;
  logic [ID_W-1:0]  head_id;

  assign rd_next        = rd_ptr + PTR_W'(1);
  assign bus.resp_valid = (count != '0);
  assign bus.resp_hash  = head_hash;
  assign bus.resp_id    = head_id;
  assign pop            = bus.resp_valid && bus.resp_ready;

  // Capture each tagged result. The write is unconditional because the credits
  // guarantee a free slot.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset. Pointers and count define which
    // entries are live, and every entry is written before it is read.
    if (wr_en) begin
      mem_hash[wr_ptr] <= hash_out_data;
      mem_id[wr_ptr]   <= wr_id;
    end
  end

  // Pointer and occupancy bookkeeping. A write and a pop in the same cycle leave the count unchanged.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)   rd_ptr <= rd_next;
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Registered head. On a pop it takes the next stored entry. If none is
  // stored, it takes the entry being written this cycle. This also covers
  // a write and a pop together at count==1, and a write into an empty FIFO.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_hash <= '0;
      head_id   <= '0;
    end else if (pop) begin
      if (count > CNT_W'(1)) begin
        head_hash <= mem_hash[rd_next];
        head_id   <= mem_id[rd_next];
      end else if (wr_en) begin
        head_hash <= hash_out_data;
        head_id   <= wr_id;
      end
    end else if (wr_en && (count == '0)) begin
      head_hash <= hash_out_data;
      head_id   <= wr_id;
    end
  end

  // ---------------------------------------------------------------------
  // Credits
  // ---------------------------------------------------------------------
  // reserved = keys in flight + FIFO entries. An accept and a pop in the same cycle cancel.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reserved <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   reserved <= reserved + CNT_W'(1);
        2'b01:   reserved <= reserved - CNT_W'(1);
        default: reserved <= reserved;
      endcase
    end
  end

  assign busy = (reserved != '0);

endmodule
